uart_rx: RTL and testbench

//  8N1 UART receiver; receive-side counterpart of uart_tx on the same serial link.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with 2-FF synchroniser, mid-bit sampling and
//            1-cycle done / framing-error strobes. Define UART_RX_PARITY_EN
//            for 8E1 frames with a parity_err strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int BAUD_MAX  = 5207,
    parameter int BAUD_HALF = BAUD_MAX / 2,
    parameter int CNT_W     = 13
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [CNT_W-1:0] C_BAUD_MAX  = CNT_W'(BAUD_MAX);
    localparam logic [CNT_W-1:0] C_BAUD_HALF = CNT_W'(BAUD_HALF);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_d;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;

    logic w_fall;
    logic w_baud_mid;
    logic w_baud_end;
    logic w_par_bad;

    assign w_fall     = r_rx_d & ~r_rx_s;
    assign w_baud_mid = (r_baud_cnt == C_BAUD_HALF);
    assign w_baud_end = (r_baud_cnt == C_BAUD_MAX);
    assign rx_busy    = (r_state != S_IDLE);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;

    // Even parity: the received parity bit must equal the XOR of the data bits.
    assign w_par_bad = (r_par_bit != ^r_shift);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_par_bit  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (r_state == S_PARITY && w_baud_mid) begin
                r_par_bit <= r_rx_s;
            end
            if (r_state == S_STOP && w_baud_mid) begin
                parity_err <= w_par_bad;
            end
        end
    end
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            rx_data    <= 8'h00;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            if (r_state == S_IDLE || w_baud_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_mid && r_rx_s) begin
                        r_state    <= S_IDLE;
                        r_baud_cnt <= '0;
                    end else if (w_baud_end) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (w_baud_mid) begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                    end
                    if (w_baud_end) begin
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid-bit so a start edge right after the stop bit is caught.
                    if (w_baud_mid) begin
                        r_state    <= S_IDLE;
                        r_baud_cnt <= '0;
                        if (r_rx_s && !w_par_bad) begin
                            rx_data <= r_shift;
                            rx_done <= 1'b1;
                        end
                        if (!r_rx_s) begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (BAUD_MAX = 50).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BIT = 51;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT_EXP = (NBITS - 1) * BIT + 25 + 4;

    logic       sclk = 1'b0;
    logic       rst  = 1'b1;
    logic       rx   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    logic [7:0] done_data = 8'h00;
    logic par_flip = 1'b0;

    uart_rx #(
        .BAUD_MAX  (50),
        .BAUD_HALF (25),
        .CNT_W     (13)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // Counts high cycles of each strobe, so a 2-cycle pulse shows up as a count error.
    always @(negedge sclk) begin
        if (rx_done) begin
            done_cnt      <= done_cnt + 1;
            done_data     <= rx_data;
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc;
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(posedge sclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        rst = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
    endtask

    task automatic test_single;
        int d0, f0, start, lat;
        logic [7:0] d;
        d  = 8'h55;
        d0 = done_cnt;
        f0 = ferr_cnt;
        start = cyc;
        send_bit(1'b0);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b expected 1", rx_busy); end
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(1'b1);
        idle_line(5);
        lat = last_done_cyc - start;
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL single_rx_data: got %h expected 55", rx_data); end
        checks++; if (done_data !== 8'h55) begin errors++; $display("FAIL single_data_at_done: got %h expected 55", done_data); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cnt - f0); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", rx_busy); end
        checks++; if (lat < LAT_EXP - 3 || lat > LAT_EXP + 3) begin errors++; $display("FAIL single_latency: got %0d expected %0d +/-3", lat, LAT_EXP); end
    endtask

    task automatic test_back_to_back;
        int d0, gap;
        idle_line(20);
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1);
        checks++; if (done_data !== 8'hA3) begin errors++; $display("FAIL b2b_first_data: got %h expected a3", done_data); end
        send_frame(8'h0F, 1'b1);
        idle_line(5);
        gap = last_done_cyc - prev_done_cyc;
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
        checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL b2b_second_data: got %h expected 0f", rx_data); end
        checks++; if (gap < NBITS * BIT - 3 || gap > NBITS * BIT + 3) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d +/-3", gap, NBITS * BIT); end
    endtask

    task automatic test_false_start;
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (10) @(posedge sclk);
        #1;
        idle_line(60);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", rx_busy); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done: got %0d expected 0", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - f0); end
        send_frame(8'h81, 1'b1);
        idle_line(5);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL glitch_next_data: got %h expected 81", rx_data); end
    endtask

    task automatic test_frame_error;
        int d0, f0;
        send_frame(8'h12, 1'b1);
        idle_line(5);
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ferr_good_data: got %h expected 12", rx_data); end
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hFF, 1'b0);
        idle_line(20);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0); end
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ferr_data_held: got %h expected 12", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_reset_mid_frame;
        int d0, f0;
        logic [7:0] d;
        d = 8'hC5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (20) @(posedge sclk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", rx_busy); end
        d0 = done_cnt;
        f0 = ferr_cnt;
        rst = 1'b1;
        #2;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", rx_busy); end
        @(posedge sclk);
        #1;
        checks++; if (rx_done !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_strobes: got %b%b%b expected 000", rx_done, frame_err, parity_err);
        end
        rst = 1'b0;
        idle_line(BIT * 8);
        checks++; if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
            errors++; $display("FAIL rstmid_no_pulse: got done %0d ferr %0d expected 0 0", done_cnt - d0, ferr_cnt - f0);
        end
        send_frame(8'h3C, 1'b1);
        idle_line(5);
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstmid_next_data: got %h expected 3c", rx_data); end
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        int d0, p0;
        d0 = done_cnt;
        p0 = perr_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        idle_line(5);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL par_good_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h expected 07", rx_data); end
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle_line(5);
        send_frame(8'h5A, 1'b1);
        idle_line(5);
        par_flip = 1'b0;
        checks++; if (perr_cnt - p0 !== 2) begin errors++; $display("FAIL par_bad_pulse: got %0d expected 2", perr_cnt - p0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL par_bad_no_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_bad_data_held: got %h expected 07", rx_data); end
`else
        checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL par_off_pulses: got %0d expected 0", perr_cnt); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_off_level: got %b expected 0", parity_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
